// File: rtl/sink_pkg.sv
// Shared constants, state encoding and width helper for the sink lookup engine.
package sink_pkg;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned NUM_SINKS = 10;
    localparam int unsigned ID_W      = 5;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        int unsigned v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction
endpackage

// File: rtl/sink_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import sink_pkg::*;
#(
    parameter int unsigned N = NUM_REQ
) (
    input  logic [N-1:0]        req,
    input  logic [clog2(N)-1:0] ptr,
    output logic [N-1:0]        grant_onehot,
    output logic [clog2(N)-1:0] grant_idx
);
    localparam int unsigned PW = clog2(N);

    int unsigned cand;

    // Walk from the farthest slot back to ptr so the nearest request overrides.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        cand         = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = (32'(ptr) + 32'(k)) % N;
            if (req[PW'(cand)]) begin
                grant_onehot              = '0;
                grant_onehot[PW'(cand)]   = 1'b1;
                grant_idx                 = PW'(cand);
            end
        end
    end
endmodule

// File: rtl/sink_lookup_arbiter.sv
// Shared sink-table lookup: arbitrates requesters, scans a snapshot of the table
// one entry per clock and returns hit/miss plus the first matching index.
module sink_lookup_arbiter
    import sink_pkg::*;
#(
    parameter int unsigned NUM_REQ   = sink_pkg::NUM_REQ,
    parameter int unsigned NUM_SINKS = sink_pkg::NUM_SINKS,
    parameter int unsigned ID_W      = sink_pkg::ID_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SINKS*ID_W-1:0]      knownSinks,
    input  logic [CNT_W-1:0]               sinkCount,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ID_W-1:0]        req_id,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    output logic [clog2(NUM_REQ)-1:0]      rsp_req,
    output logic                           rsp_hit,
    output logic [clog2(NUM_SINKS)-1:0]    rsp_index,
    input  logic                           rsp_ready
);
    localparam int unsigned REQ_W = clog2(NUM_REQ);
    localparam int unsigned IDX_W = clog2(NUM_SINKS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_SINKS);

    state_t             state;
    logic [REQ_W-1:0]   rrPtr;
    logic [REQ_W-1:0]   grantIdx;
    logic [NUM_REQ-1:0] grantOneHot;
    logic [IDX_W-1:0]   scanIdx;
    logic [CNT_W-1:0]   countSnap;
    logic [CNT_W-1:0]   clampedCount;
    logic [ID_W-1:0]    argId;
    logic [ID_W-1:0]    tableSnap [NUM_SINKS];
    logic               accept;
    logic               entryHit;
    logic               lastEntry;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req          (req_valid),
        .ptr          (rrPtr),
        .grant_onehot (grantOneHot),
        .grant_idx    (grantIdx)
    );

    assign req_ready    = (state == ST_IDLE && !reset) ? grantOneHot : '0;
    assign accept       = (state == ST_IDLE) && (|grantOneHot);
    assign clampedCount = (sinkCount > MAX_CNT) ? MAX_CNT : sinkCount;
    assign entryHit     = (tableSnap[scanIdx] == argId);
    assign lastEntry    = (CNT_W'(scanIdx) == countSnap - CNT_W'(1));

    // Lookup sequencer: snapshot on accept, linear scan, hold response until retired.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rrPtr     <= '0;
            scanIdx   <= '0;
            countSnap <= '0;
            argId     <= '0;
            rsp_valid <= 1'b0;
            rsp_req   <= '0;
            rsp_hit   <= 1'b0;
            rsp_index <= '0;
            for (int j = 0; j < int'(NUM_SINKS); j++) tableSnap[j] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        argId     <= req_id[32'(grantIdx)*ID_W +: ID_W];
                        rsp_req   <= grantIdx;
                        rrPtr     <= (grantIdx == REQ_W'(NUM_REQ - 1)) ? '0 : grantIdx + REQ_W'(1);
                        countSnap <= clampedCount;
                        scanIdx   <= '0;
                        for (int j = 0; j < int'(NUM_SINKS); j++)
                            tableSnap[j] <= knownSinks[ID_W*j +: ID_W];
                        if (clampedCount == '0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_hit   <= 1'b0;
                            rsp_index <= '0;
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (entryHit) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_index <= scanIdx;
                    end else if (lastEntry) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_index <= '0;
                    end else begin
                        scanIdx <= scanIdx + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
